accum_bank: RTL and testbench

Multi-column accumulator bank at the output of the systolic array. Each cycle it accepts one row of NUM_COL partial sums and read-modify-writes them into per-column accumulator memories, with full throughput and hazard forwarding for back-to-back hits on the same row. A low-priority read port drains finished rows to the output/activation stage.

---
 rtl/accum_pkg.sv | 44 ++++
 rtl/accum_bank_if.sv | 31 +++
 rtl/accum_col_ram.sv | 33 +++
 rtl/accum_bank.sv | 128 ++++++++++++
 tb/tb_accum_bank.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/accum_pkg.sv
// Shared types, default parameters and lane arithmetic for the accumulator bank.
// Optional build macro: ACCUM_SAT_EN (signed saturating lane adds instead of wrap).
package accum_pkg;

  localparam int unsigned ACC_NUM_COL_DEF = 16;
  localparam int unsigned ACC_ROW_DEF     = 256;
  localparam int unsigned ACC_DATA_W_DEF  = 32;
  localparam int unsigned ACC_ACC_W_DEF   = 32;

  // Container width for the width-generic lane function; ACC_WIDTH must fit.
  localparam int unsigned ACC_W_MAX = 64;
  localparam int unsigned ACC_W_IDX = $clog2(ACC_W_MAX);

  typedef enum logic {
    ACC_MODE_ADD = 1'b0,
    ACC_MODE_OVR = 1'b1
  } acc_mode_e;

  // Signed saturating add of two w-bit values held zero-padded in the low bits.
  // Overflow: operands share a sign and the result sign differs from it.
  function automatic logic [ACC_W_MAX-1:0] lane_sat_add(
    input logic [ACC_W_MAX-1:0] a,
    input logic [ACC_W_MAX-1:0] b,
    input int unsigned          w
  );
    logic [ACC_W_MAX-1:0] mask;
    logic [ACC_W_MAX-1:0] sum;
    logic [ACC_W_MAX-1:0] max_pos;
    logic                 sa;
    logic                 sb;
    logic                 ss;
    mask    = (w >= ACC_W_MAX) ? '1 : ((ACC_W_MAX'(1) << w) - ACC_W_MAX'(1));
    sum     = (a + b) & mask;
    max_pos = mask >> 1;
    sa      = a[ACC_W_IDX'(w - 1)];
    sb      = b[ACC_W_IDX'(w - 1)];
    ss      = sum[ACC_W_IDX'(w - 1)];
    if ((sa == sb) && (ss != sa)) begin
      sum = sa ? (max_pos + ACC_W_MAX'(1)) : max_pos;
    end
    return sum;
  endfunction

endpackage

// File: rtl/accum_bank_if.sv
// Accumulate and drain bus between the systolic array and the accumulator bank.
interface accum_bank_if #(
  parameter int unsigned NUM_COL    = accum_pkg::ACC_NUM_COL_DEF,
  parameter int unsigned DATA_WIDTH = accum_pkg::ACC_DATA_W_DEF,
  parameter int unsigned ACC_WIDTH  = accum_pkg::ACC_ACC_W_DEF,
  parameter int unsigned ADDR_WIDTH = $clog2(accum_pkg::ACC_ROW_DEF)
);
  import accum_pkg::*;

  logic                          in_valid;
  acc_mode_e                     in_mode;
  logic [ADDR_WIDTH-1:0]         in_addr;
  logic [NUM_COL*DATA_WIDTH-1:0] in_data;
  logic                          rd_req;
  logic [ADDR_WIDTH-1:0]         rd_addr;
  logic                          rd_ready;
  logic                          rd_valid;
  logic [NUM_COL*ACC_WIDTH-1:0]  rd_data;
  logic                          busy;

  modport master (
    output in_valid, in_mode, in_addr, in_data, rd_req, rd_addr,
    input  rd_ready, rd_valid, rd_data, busy
  );

  modport slave (
    input  in_valid, in_mode, in_addr, in_data, rd_req, rd_addr,
    output rd_ready, rd_valid, rd_data, busy
  );

endinterface

// File: rtl/accum_col_ram.sv
// One column of accumulator storage: simple dual-port, synchronous read,
// read-during-write returns the old word. Behavioural array; swap the body
// for a memory macro with the same port behaviour.
module accum_col_ram #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q;

  // Write port and registered read port; both non-blocking so a same-address read sees old data
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_q <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/accum_bank.sv
// Multi-column accumulator bank: two-stage read-modify-write at one row per
// cycle with last-write forwarding, plus a low-priority drain port.
// Optional build macro: ACCUM_SAT_EN (saturating lanes instead of wrap).
module accum_bank #(
  parameter int unsigned NUM_COL    = accum_pkg::ACC_NUM_COL_DEF,
  parameter int unsigned ACCUM_ROW  = accum_pkg::ACC_ROW_DEF,
  parameter int unsigned DATA_WIDTH = accum_pkg::ACC_DATA_W_DEF,
  parameter int unsigned ACC_WIDTH  = accum_pkg::ACC_ACC_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  accum_bank_if.slave  bus
);
  import accum_pkg::*;

  localparam int unsigned ADDR_WIDTH = $clog2(ACCUM_ROW);
  localparam int unsigned IN_W       = NUM_COL * DATA_WIDTH;
  localparam int unsigned ROW_W      = NUM_COL * ACC_WIDTH;

  logic                  r_s1_valid;
  acc_mode_e             r_s1_mode;
  logic [ADDR_WIDTH-1:0] r_s1_addr;
  logic [IN_W-1:0]       r_s1_data;
  logic                  r_lw_valid;
  logic [ADDR_WIDTH-1:0] r_lw_addr;
  logic [ROW_W-1:0]      r_lw_row;
  logic                  r_rd_pend;
  logic [ADDR_WIDTH-1:0] r_rd_addr;

  logic                  w_rd_ready;
  logic                  w_re;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_raddr;
  logic [ROW_W-1:0]      w_ram_q;
  logic [ROW_W-1:0]      w_base;
  logic [ROW_W-1:0]      w_sum;
  logic [ROW_W-1:0]      w_rd_row;
  logic                  w_lw_hit_s1;
  logic                  w_s1_hit_rd;
  logic                  w_lw_hit_rd;

  // Shared read port: accumulate wins, drain only on idle cycles
  assign w_rd_ready = bus.rd_req & ~bus.in_valid;
  assign w_re       = bus.in_valid | w_rd_ready;
  assign w_raddr    = bus.in_valid ? bus.in_addr : bus.rd_addr;
  // A write still in S1 when reset hits is dropped
  assign w_we       = r_s1_valid & ~rst;

  assign w_lw_hit_s1 = r_lw_valid && (r_lw_addr == r_s1_addr);
  assign w_s1_hit_rd = r_s1_valid && (r_s1_addr == r_rd_addr);
  assign w_lw_hit_rd = r_lw_valid && (r_lw_addr == r_rd_addr);

  // Base row for S1: zero on overwrite, else last write if it targets this row, else RAM
  assign w_base = (r_s1_mode == ACC_MODE_OVR) ? '0 :
                  (w_lw_hit_s1 ? r_lw_row : w_ram_q);

  for (genvar c = 0; c < NUM_COL; c++) begin : g_lane
    logic [ACC_WIDTH-1:0] w_ext;

    assign w_ext = ACC_WIDTH'($signed(r_s1_data[c*DATA_WIDTH +: DATA_WIDTH]));

`ifdef ACCUM_SAT_EN
    assign w_sum[c*ACC_WIDTH +: ACC_WIDTH] =
      ACC_WIDTH'(lane_sat_add(ACC_W_MAX'(w_base[c*ACC_WIDTH +: ACC_WIDTH]),
                              ACC_W_MAX'(w_ext), ACC_WIDTH));
`else
    assign w_sum[c*ACC_WIDTH +: ACC_WIDTH] = w_base[c*ACC_WIDTH +: ACC_WIDTH] + w_ext;
`endif

    accum_col_ram #(
      .DEPTH      (ACCUM_ROW),
      .WIDTH      (ACC_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_s1_addr),
      .i_wdata (w_sum[c*ACC_WIDTH +: ACC_WIDTH]),
      .i_re    (w_re),
      .i_raddr (w_raddr),
      .o_rdata (w_ram_q[c*ACC_WIDTH +: ACC_WIDTH])
    );
  end

  // Drain data: in-flight S1 sum first, then last write, then RAM
  assign w_rd_row = w_s1_hit_rd ? w_sum : (w_lw_hit_rd ? r_lw_row : w_ram_q);

  // Control state: S1 valid, last-write valid, drain pending
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_lw_valid <= 1'b0;
      r_rd_pend  <= 1'b0;
    end else begin
      r_s1_valid <= bus.in_valid;
      r_lw_valid <= r_s1_valid;
      r_rd_pend  <= w_rd_ready;
    end
  end

  // Datapath capture; qualified by the valid flags above so no reset needed
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      r_s1_mode <= bus.in_mode;
      r_s1_addr <= bus.in_addr;
      r_s1_data <= bus.in_data;
    end
    if (r_s1_valid) begin
      r_lw_addr <= r_s1_addr;
      r_lw_row  <= w_sum;
    end
    if (w_rd_ready) begin
      r_rd_addr <= bus.rd_addr;
    end
  end

  assign bus.rd_ready = w_rd_ready;
  assign bus.rd_valid = r_rd_pend;
  assign bus.rd_data  = r_rd_pend ? w_rd_row : '0;
  assign bus.busy     = r_s1_valid;

  // Row addresses beyond the bank are illegal
  a_in_addr: assert property (@(posedge clk) disable iff (rst)
    bus.in_valid |-> (32'(bus.in_addr) < ACCUM_ROW));
  a_rd_addr: assert property (@(posedge clk) disable iff (rst)
    w_rd_ready |-> (32'(bus.rd_addr) < ACCUM_ROW));

endmodule

// File: tb/tb_accum_bank.sv
// Directed self-checking bench for accum_bank (default parameters).
module tb_accum_bank;
  import accum_pkg::*;

  localparam int unsigned NUM_COL = 16;
  localparam int unsigned ROWS    = 256;
  localparam int unsigned DW      = 32;
  localparam int unsigned AW      = 32;
  localparam int unsigned ADW     = 8;
  localparam int unsigned IN_W    = NUM_COL * DW;
  localparam int unsigned ROW_W   = NUM_COL * AW;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  accum_bank_if #(.NUM_COL(NUM_COL), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW)) bus ();

  accum_bank #(.NUM_COL(NUM_COL), .ACCUM_ROW(ROWS), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IN_W-1:0] fill_in(input logic [DW-1:0] v);
    return {NUM_COL{v}};
  endfunction

  function automatic logic [ROW_W-1:0] fill_row(input logic [AW-1:0] v);
    return {NUM_COL{v}};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One accumulate request, accepted at the next edge
  task automatic issue(input logic [ADW-1:0] a, input acc_mode_e m, input logic [IN_W-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_addr  = a;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // One drain request on an idle port; returns what appears the cycle after
  task automatic drain(input logic [ADW-1:0] a, output logic vld, output logic [ROW_W-1:0] d);
    bus.rd_req  = 1'b1;
    bus.rd_addr = a;
    @(posedge clk);
    #1;
    bus.rd_req = 1'b0;
    vld = bus.rd_valid;
    d   = bus.rd_data;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_mode  = ACC_MODE_ADD;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    idle(2);
    n_tests++;
    if (bus.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rd_valid got %b exp 0", bus.rd_valid);
    end
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy);
    end
    n_tests++;
    if (bus.rd_data !== '0) begin
      n_fail++; $display("FAIL reset_rd_data got %h exp 0", bus.rd_data);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_overwrite_accum();
    logic             vld;
    logic [ROW_W-1:0] d;
    issue(8'd3, ACC_MODE_OVR, fill_in(32'd5));
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_after_accept got %b exp 1", bus.busy);
    end
    issue(8'd3, ACC_MODE_ADD, fill_in(32'd7));
    drain(8'd3, vld, d);
    n_tests++;
    if (vld !== 1'b1) begin
      n_fail++; $display("FAIL ovr_acc_valid got %b exp 1", vld);
    end
    n_tests++;
    if (d !== fill_row(32'd12)) begin
      n_fail++; $display("FAIL ovr_acc_data got %h exp %h", d, fill_row(32'd12));
    end
  endtask

  task automatic test_back_to_back();
    logic             vld;
    logic [ROW_W-1:0] d;
    issue(8'd10, ACC_MODE_OVR, fill_in(32'd0));
    for (int i = 0; i < 4; i++) issue(8'd10, ACC_MODE_ADD, fill_in(32'd1));
    drain(8'd10, vld, d);
    n_tests++;
    if (d !== fill_row(32'd4)) begin
      n_fail++; $display("FAIL b2b_accum got %h exp %h", d, fill_row(32'd4));
    end
    idle(1);
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_idle got %b exp 0", bus.busy);
    end
  endtask

  task automatic test_s1_forward();
    logic             vld;
    logic [ROW_W-1:0] d;
    issue(8'd9, ACC_MODE_OVR, fill_in(32'd100));
    idle(2);
    issue(8'd9, ACC_MODE_ADD, fill_in(32'd2));
    drain(8'd9, vld, d);
    n_tests++;
    if (d !== fill_row(32'd102)) begin
      n_fail++; $display("FAIL s1_fwd got %h exp %h", d, fill_row(32'd102));
    end
  endtask

  task automatic test_back_to_back_drain();
    logic             v0;
    logic             v1;
    logic [ROW_W-1:0] d0;
    logic [ROW_W-1:0] d1;
    drain(8'd3, v0, d0);
    drain(8'd10, v1, d1);
    n_tests++;
    if ({v0, v1} !== 2'b11) begin
      n_fail++; $display("FAIL drain_b2b_valid got %b exp 11", {v0, v1});
    end
    n_tests++;
    if (d0 !== fill_row(32'd12) || d1 !== fill_row(32'd4)) begin
      n_fail++; $display("FAIL drain_b2b_data got %h / %h exp 12 / 4 per lane", d0[31:0], d1[31:0]);
    end
  endtask

  task automatic test_drain_starve();
    issue(8'd4, ACC_MODE_OVR, fill_in(32'd33));
    idle(2);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 8'd4;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_mode  = ACC_MODE_OVR;
      bus.in_addr  = 8'd6;
      bus.in_data  = fill_in(32'd0);
      #1;
      n_tests++;
      if (bus.rd_ready !== 1'b0) begin
        n_fail++; $display("FAIL starve_rd_ready cycle %0d got %b exp 0", i, bus.rd_ready);
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    #1;
    n_tests++;
    if (bus.rd_ready !== 1'b1) begin
      n_fail++; $display("FAIL starve_release_ready got %b exp 1", bus.rd_ready);
    end
    @(posedge clk);
    #1;
    bus.rd_req = 1'b0;
    n_tests++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== fill_row(32'd33)) begin
      n_fail++; $display("FAIL starve_data got v=%b %h exp v=1 33 per lane", bus.rd_valid, bus.rd_data[31:0]);
    end
    idle(1);
    n_tests++;
    if (bus.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL rd_valid_pulse got %b exp 0", bus.rd_valid);
    end
  endtask

  task automatic test_saturation();
    logic             vld;
    logic [ROW_W-1:0] d;
    logic [AW-1:0]    exp_hi;
    logic [AW-1:0]    exp_lo;
`ifdef ACCUM_SAT_EN
    exp_hi = 32'h7FFF_FFFF;
    exp_lo = 32'h8000_0000;
`else
    exp_hi = 32'h8000_0010;
    exp_lo = 32'h7FFF_FFF0;
`endif
    issue(8'd7, ACC_MODE_OVR, fill_in(32'h7FFF_FFF0));
    issue(8'd7, ACC_MODE_ADD, fill_in(32'h0000_0020));
    drain(8'd7, vld, d);
    n_tests++;
    if (d !== fill_row(exp_hi)) begin
      n_fail++; $display("FAIL pos_overflow got %h exp %h per lane", d[31:0], exp_hi);
    end
    issue(8'd8, ACC_MODE_OVR, fill_in(32'h8000_0010));
    issue(8'd8, ACC_MODE_ADD, fill_in(32'hFFFF_FFE0));
    drain(8'd8, vld, d);
    n_tests++;
    if (d !== fill_row(exp_lo)) begin
      n_fail++; $display("FAIL neg_overflow got %h exp %h per lane", d[31:0], exp_lo);
    end
  endtask

  task automatic test_lanes();
    logic             vld;
    logic [ROW_W-1:0] d;
    logic [IN_W-1:0]  d_ovr;
    logic [IN_W-1:0]  d_add;
    logic [ROW_W-1:0] exp_row;
    for (int i = 0; i < NUM_COL; i++) begin
      d_ovr[i*DW +: DW]   = 32'(i);
      d_add[i*DW +: DW]   = 32'h100 + 32'(i);
      exp_row[i*AW +: AW] = 32'h100 + 32'(2 * i) - 32'd1;
    end
    issue(8'd11, ACC_MODE_OVR, d_ovr);
    issue(8'd11, ACC_MODE_ADD, d_add);
    issue(8'd11, ACC_MODE_ADD, fill_in(32'hFFFF_FFFF));
    drain(8'd11, vld, d);
    n_tests++;
    if (d !== exp_row) begin
      n_fail++; $display("FAIL lane_packing got %h exp %h", d, exp_row);
    end
  endtask

  task automatic test_reset_midop();
    logic             vld;
    logic [ROW_W-1:0] d;
    issue(8'd20, ACC_MODE_OVR, fill_in(32'd50));
    idle(2);
    issue(8'd20, ACC_MODE_ADD, fill_in(32'd5));
    rst         = 1'b1;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 8'd20;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    bus.rd_req = 1'b0;
    n_tests++;
    if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL midop_reset got v=%b busy=%b exp 0 0", bus.rd_valid, bus.busy);
    end
    idle(1);
    drain(8'd20, vld, d);
    n_tests++;
    if (vld !== 1'b1 || d !== fill_row(32'd50)) begin
      n_fail++; $display("FAIL midop_dropped got v=%b %h exp v=1 50 per lane", vld, d[31:0]);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_overwrite_accum();
    test_back_to_back();
    test_s1_forward();
    test_back_to_back_drain();
    test_drain_starve();
    test_saturation();
    test_lanes();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
